// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int          ITER_DEFAULT = 32;
  localparam int          ITER_W       = $clog2(ITER_DEFAULT + 1);
  localparam logic [31:0] DZ_QUOTIENT  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  // Accepted-op encoding after strobe priority resolution.
  typedef enum logic [1:0] {
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU
  } op_t;

  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } mode_t;

  // Magnitude for signed ops, raw value for unsigned ops.
  // The magnitude of 0x80000000 is 0x80000000 read as unsigned.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Single iteration of the shared datapath, purely combinational.
// MUL: acc = {partial_hi, multiplier}; add the multiplicand on acc[0] and shift right.
// DIV: acc = {remainder, dividend}; shift left, trial-subtract the divisor, and restore on borrow.
// The quotient bits are shifted into acc[31:0] as the dividend bits leave.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  mode_t       mode,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  output logic [63:0] acc_next
);

  logic [32:0] add_sum;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic        diff_unused;

  // The remainder stays below the divisor, so diff[32] is always zero when there is no borrow.
  assign diff_unused = diff[32];

  // One shift-add or shift-subtract-restore step.
  always_comb begin
    add_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    rem_sh  = {acc[63:32], acc[31]};
    diff    = {1'b0, rem_sh} - {2'b00, opnd};
    if (mode == MODE_MUL) begin
      acc_next = {add_sum, acc[31:1]};
    end else if (diff[33]) begin
      acc_next = {rem_sh[31:0], acc[30:0], 1'b0};
    end else begin
      acc_next = {diff[31:0], acc[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit that owns HI/LO for the cpu55 core.
//
// state | meaning
// IDLE  | accept arithmetic op or mthi/mtlo
// MUL   | ITER shift-add steps
// DIV   | ITER restoring-divide steps
// FIX   | sign fixup, write HI/LO, pulse done
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mult,
  input  logic        multu,
  input  logic        div,
  input  logic        divu,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] rs_in,
  input  logic [31:0] rt_in,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITER - 1);

  state_t            state, state_nxt;
  op_t               op_sel;
  mode_t             iter_mode;
  logic              arith, sign_op, mul_op, last_iter;
  logic [ITER_W-1:0] cnt;
  logic [63:0]       acc, acc_step, prod;
  logic [31:0]       opnd, rs_raw, hi, lo, quo, rem;
  logic              neg_q, neg_r, is_div, done_q, dz_q;

  // Strobe priority: mult > multu > div > divu.
  always_comb begin
    arith  = mult | multu | div | divu;
    op_sel = OP_MULT;
    if (mult)       op_sel = OP_MULT;
    else if (multu) op_sel = OP_MULTU;
    else if (div)   op_sel = OP_DIV;
    else if (divu)  op_sel = OP_DIVU;
    sign_op   = (op_sel == OP_MULT) || (op_sel == OP_DIV);
    mul_op    = (op_sel == OP_MULT) || (op_sel == OP_MULTU);
    last_iter = (cnt == LAST_ITER);
    iter_mode = (state == DIV) ? MODE_DIV : MODE_MUL;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arith) state_nxt = mul_op ? MUL : DIV;
      MUL:     if (last_iter) state_nxt = FIX;
      DIV:     if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: busy covers the iterations and the fixup cycle.
  always_comb begin
    busy   = (state != IDLE);
    done   = done_q;
    dz     = dz_q;
    hi_out = hi;
    lo_out = lo;
  end

  muldiv_iter u_iter (
    .mode     (iter_mode),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_step)
  );

  // Sign fixup of the unsigned result; truncation makes 0x80000000 / -1 wrap back to 0x80000000.
  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[31:0] : acc[31:0];
    rem  = neg_r ? -acc[63:32] : acc[63:32];
  end

  // Operand capture, iteration, counter, and the HI/LO/done/dz registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      rs_raw <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (arith) begin
            cnt    <= '0;
            rs_raw <= rs_in;
            neg_q  <= sign_op & (rs_in[31] ^ rt_in[31]);
            neg_r  <= sign_op & rs_in[31];
            is_div <= ~mul_op;
            dz_q   <= 1'b0;
            if (mul_op) begin
              acc  <= {32'd0, mag(rt_in, sign_op)};
              opnd <= mag(rs_in, sign_op);
            end else begin
              acc  <= {32'd0, mag(rs_in, sign_op)};
              opnd <= mag(rt_in, sign_op);
            end
          end else begin
            if (mthi) hi <= rs_in;
            if (mtlo) lo <= rs_in;
          end
        end
        MUL, DIV: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          done_q <= 1'b1;
          if (is_div) begin
            if (opnd == '0) begin
              hi   <= rs_raw;
              lo   <= DZ_QUOTIENT;
              dz_q <= 1'b1;
            end else begin
              hi <= rem;
              lo <= quo;
            end
          end else begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed cases and random ops against an arithmetic reference.
module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        rst, mult, multu, div, divu, mthi, mtlo;
  logic [31:0] rs_in, rt_in;
  logic        busy, done, dz;
  logic [31:0] hi_out, lo_out;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic        dz_m = 1'b0;

  always #5 clk = ~clk;

  muldiv_hilo #(.ITER(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .mult   (mult),
    .multu  (multu),
    .div    (div),
    .divu   (divu),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .rs_in  (rs_in),
    .rt_in  (rt_in),
    .busy   (busy),
    .done   (done),
    .dz     (dz),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result {dz, hi, lo} from plain 64-bit arithmetic.
  // op: 0 mult, 1 multu, 2 div, 3 divu.
  function automatic logic [64:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, pu, qu, ru;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      0: begin p = sa * sb; return {1'b0, p}; end
      1: begin pu = ua * ub; return {1'b0, pu}; end
      2: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        qu = ua / ub;
        ru = ua % ub;
        return {1'b0, ru[31:0], qu[31:0]};
      end
    endcase
  endfunction

  // Issue an arithmetic op (plus optional lower-priority strobes), optionally poke mthi mid-op.
  task automatic run_op(input int op, input logic [3:0] extra, input logic [31:0] a,
                        input logic [31:0] b, input int poke);
    logic [64:0] r;
    logic [3:0]  s, top;
    int          n, busy_cycles;
    r   = model(op, a, b);
    top = 4'b1000 >> op;
    s   = top | (extra & (top - 4'd1));
    @(negedge clk);
    {mult, multu, div, divu} = s;
    rs_in = a;
    rt_in = b;
    @(posedge clk);
    #1 {mult, multu, div, divu} = 4'b0000;
    n = 0;
    busy_cycles = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      busy_cycles++;
      n++;
      mthi = 1'b0;
      if (n == 17) begin
        check("hold_hi", hi_out, hi_m);
        check("hold_lo", lo_out, lo_m);
      end
      if (n == poke) begin
        mthi  = 1'b1;
        rs_in = '0;
      end
      @(negedge clk);
    end
    mthi = 1'b0;
    hi_m = r[63:32];
    lo_m = r[31:0];
    dz_m = r[64];
    check("busy_cycles", 64'(busy_cycles), 64'd33);
    check("busy_end", busy, 1'b0);
    check("done_pulse", done, 1'b1);
    check("hi", hi_out, hi_m);
    check("lo", lo_out, lo_m);
    check("dz", dz, dz_m);
    @(negedge clk);
    check("done_clear", done, 1'b0);
  endtask

  task automatic move_to(input logic wh, input logic wl, input logic [31:0] v);
    @(negedge clk);
    mthi  = wh;
    mtlo  = wl;
    rs_in = v;
    @(posedge clk);
    #1 begin mthi = 1'b0; mtlo = 1'b0; end
    if (wh) hi_m = v;
    if (wl) lo_m = v;
    @(negedge clk);
    check("mt_hi", hi_out, hi_m);
    check("mt_lo", lo_out, lo_m);
    check("mt_busy", busy, 1'b0);
    check("mt_done", done, 1'b0);
  endtask

  task automatic abort_test();
    int seen;
    @(negedge clk);
    divu  = 1'b1;
    rs_in = 32'd50;
    rt_in = 32'd5;
    @(posedge clk);
    #1 divu = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    hi_m = '0;
    lo_m = '0;
    dz_m = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi_out, 32'd0);
    check("abort_lo", lo_out, 32'd0);
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(seen), 64'd0);
  endtask

  initial begin
    int          kind;
    logic [31:0] a, b;
    rst = 1'b1;
    {mult, multu, div, divu, mthi, mtlo} = '0;
    rs_in = '0;
    rt_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dz", dz, 1'b0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    rst = 1'b0;

    run_op(0, 4'b0000, 32'hFFFF_FFFD, 32'd7, -1);
    run_op(1, 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(3, 4'b0000, 32'd100, 32'd7, -1);
    run_op(2, 4'b0000, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(2, 4'b0000, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(2, 4'b0000, 32'h1234_5678, 32'd0, -1);
    run_op(1, 4'b0000, 32'd2, 32'd3, -1);
    move_to(1'b1, 1'b1, 32'hA5A5_A5A5);
    run_op(2, 4'b0000, 32'hFFFF_FFF9, 32'd2, 5);
    run_op(0, 4'b0111, 32'd9, 32'hFFFF_FFFB, -1);
    abort_test();
    run_op(3, 4'b0000, 32'd50, 32'd5, -1);

    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 4);
      a = $urandom;
      b = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
      if (kind == 4) begin
        case ($urandom_range(0, 2))
          0:       move_to(1'b1, 1'b0, a);
          1:       move_to(1'b0, 1'b1, a);
          default: move_to(1'b1, 1'b1, a);
        endcase
      end else begin
        run_op(kind, 4'($urandom), a, b, ($urandom_range(0, 1) == 0) ? -1 : 9);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Multi-cycle multiply/divide unit that owns the HI/LO register pair and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO for the cpu55 core. It sits beside the core on the HI/LO path. It accepts operands from rs/rt, reports `busy` so the core stalls dependent MFHI/MFLO and new ops, and publishes HI/LO continuously for the read mux. It replaces combinational multiply and pipelined-divider instances with one iterative shift-add / restoring-divide datapath.

## Interface
Parameters:
- `ITER`, 32: iteration count, equal to the operand width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mult`  in  1  signed-multiply strobe.
- `multu`  in  1  unsigned-multiply strobe.
- `div`  in  1  signed-divide strobe.
- `divu`  in  1  unsigned-divide strobe.
- `mthi`  in  1  write `rs_in` to HI.
- `mtlo`  in  1  write `rs_in` to LO.
- `rs_in`  in  32  multiplicand / dividend / move-to data.
- `rt_in`  in  32  multiplier / divisor.
- `busy`  out  1  operation in flight; the core must stall MFHI/MFLO and new ops.
- `done`  out  1  one-cycle pulse after HI/LO are written by an arithmetic op.
- `dz`  out  1  sticky flag: the last divide had divisor 0. Cleared by the next accepted arithmetic op.
- `hi_out`  out  32  current HI.
- `lo_out`  out  32  current LO.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Reset: state IDLE, HI=LO=0, `busy`=0, `done`=0, `dz`=0, iteration counter 0.
- Accepting an op in IDLE:
  - Arithmetic strobes take priority in the order mult > multu > div > divu. Only the highest one is accepted.
  - mthi/mtlo are honoured only when no arithmetic strobe is high. Both may be high together, and then both write in the same edge. No busy is raised.
- Accepting an arithmetic op:
  - Capture |rs|, |rt| (signed ops) or the raw values (unsigned ops).
  - Capture the result sign flags and clear the counter.
  - Go to MUL or DIV.
- MUL: one shift-add step per cycle on a 64-bit accumulator. After `ITER` steps, go to FIX.
- DIV: one restoring step per cycle. Shift the remainder left, bring in the next dividend bit, subtract the divisor, restore on borrow. After `ITER` steps, go to FIX.
- FIX: write HI/LO, pulse `done`, return to IDLE.
- Sign rules:
  - Product: negated if sign(rs)≠sign(rt).
  - Quotient (LO): negated if the signs differ.
  - Remainder (HI): takes the sign of the dividend.
  - Truncate to 32 bits. So 0x80000000 / −1 gives LO=0x80000000, HI=0.
- Divide by zero (div or divu): HI=rs_in as captured (original, not magnitude), LO=0xFFFFFFFF, `dz`=1. The same 33-cycle latency applies.
- All strobes are ignored while `busy`=1, including mthi/mtlo.
- `rst` mid-operation aborts the op: the next cycle is IDLE, HI=LO=0, and no `done` pulse is produced.

## Timing
- Edge E0 accepts the op. `busy`=1 from the cycle after E0 through the cycle ending at E33, which is 33 cycles.
- E1..E32 are the iterations. E33 (FIX) writes HI/LO.
- `done`=1 and the new `hi_out`/`lo_out` are visible in the cycle after E33. `busy`=0 in that same cycle. The core may issue the next op or MFHI/MFLO in that cycle.
- mthi/mtlo: written at the accept edge and visible the next cycle. Latency is 1, with no `done`.
- `hi_out`/`lo_out` hold their old values throughout an operation.
- A strobe held high across the `busy`→0 transition is accepted as a new op. The core must deassert strobes it has already issued.

## Structure
- Package `muldiv_pkg` holds:
  - the state enum (IDLE, MUL, DIV, FIX);
  - the op-select encoding;
  - `ITER_W` = $clog2(ITER+1);
  - the constant `DZ_QUOTIENT` = 32'hFFFFFFFF.
- One sub-module, `muldiv_iter`, is natural. It is the combinational single-step datapath: shift-add for multiply, shift-subtract-restore for divide, selected by mode. The top keeps the FSM, counter, sign fixup and HI/LO registers.

## Test plan
- mult rs=0xFFFFFFFD, rt=7 -> busy for 33 cycles, then done, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then divu 100/7 -> LO=14, HI=2, dz=0.
- div rs=−7 (0xFFFFFFF9), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- div rs=0x12345678, rt=0 -> HI=0x12345678, LO=0xFFFFFFFF, dz=1. A following multu 2×3 -> dz=0, LO=6, HI=0.
- In IDLE, mthi=mtlo=1 with rs=0xA5A5A5A5 -> both HI and LO read 0xA5A5A5A5 next cycle, busy stays 0. mthi with rs=0 pulsed during a divide -> ignored, HI keeps the value written by the divide.
- divu 50/5 started, rst pulsed on iteration 10 -> next cycle busy=0, HI=LO=0, no done pulse. A fresh divu 50/5 afterwards -> LO=10, HI=0.
